// File: rtl/jt10_adpcmb_mch.sv
// Multi-channel ADPCM-B decoder: one shared 4-stage pipeline, per-channel x/step register arrays.
// Latency: a nibble accepted on cen edge k writes back and strobes pcm_valid after cen edge k+4.
// Backpressure: rdy drops while adv_ch is still in stages I..III; refused or disabled nibbles are dropped.
//
// Ports:
//   rst_n, clk, cen      : async active-low reset, clock, clock enable (all state moves only on cen)
//   data, adv, adv_ch    : nibble (bit3 sign, bits2:0 magnitude), request strobe, target channel
//   rdy                  : request would be accepted on this cen (combinational)
//   chon, clr            : per-channel enable mask, per-channel clear pulses (latched across cen=0)
//   pcm, pcm_ch          : last result and its channel; pcm_valid is a one-cen-cycle strobe
//   pcm_all              : current sample of every channel, channel 0 in the LSBs
module jt10_adpcmb_mch #(
  parameter int CH      = 2,
  parameter int CW      = (CH > 1) ? $clog2(CH) : 1,
  parameter int STEPMIN = 127,
  parameter int STEPMAX = 24576
) (
  input  logic                rst_n,
  input  logic                clk,
  input  logic                cen,
  input  logic [3:0]          data,
  input  logic                adv,
  input  logic [CW-1:0]       adv_ch,
  output logic                rdy,
  input  logic [CH-1:0]       chon,
  input  logic [CH-1:0]       clr,
  output logic signed [15:0]  pcm,
  output logic [CW-1:0]       pcm_ch,
  output logic                pcm_valid,
  output logic [CH*16-1:0]    pcm_all
);

  // per-channel state
  logic signed [16:0] x_q    [CH];
  logic [14:0]        step_q [CH];
  logic [CH-1:0]      clr_pend_q;

  // stage I
  logic               s1_vld_q, s1_sign_q;
  logic [3:0]         s1_d_q;
  logic [CW-1:0]      s1_ch_q;
  // stage II
  logic               s2_vld_q, s2_sign_q;
  logic [15:0]        s2_delta_q;
  logic [16:0]        s2_nstep_q;
  logic [CW-1:0]      s2_ch_q;
  // stage III
  logic               s3_vld_q, s3_sign_q;
  logic [16:0]        s3_delta_q;
  logic [16:0]        s3_nstep_q;
  logic [CW-1:0]      s3_ch_q;
  // stage IV (write-back register)
  logic               s4_vld_q;
  logic signed [16:0] s4_x_q;
  logic [14:0]        s4_step_q;
  logic [CW-1:0]      s4_ch_q;

  // A channel is killed this cen cycle when disabled or cleared (live or latched clear).
  logic [CH-1:0] kill;
  assign kill = ~chon | clr | clr_pend_q;

  logic adv_hit, adv_kill, accept;

  always_comb begin
    adv_hit  = 1'b0;
    adv_kill = 1'b1;
    for (int n = 0; n < CH; n++) begin
      if (adv_ch == CW'(n)) begin
        adv_hit  = 1'b1;
        adv_kill = kill[n];
      end
    end
    rdy = adv_hit;
    // Stage IV is not checked: its write lands on the same edge a new request enters
    // stage I, and the new request only reads step/x in later stages.
    if (s1_vld_q && s1_ch_q == adv_ch) rdy = 1'b0;
    if (s2_vld_q && s2_ch_q == adv_ch) rdy = 1'b0;
    if (s3_vld_q && s3_ch_q == adv_ch) rdy = 1'b0;
  end

  assign accept = adv & rdy & ~adv_kill;

  // stage II arithmetic
  logic [14:0] step_rd;
  logic [7:0]  mult;
  logic [15:0] delta_d;
  logic [16:0] nstep_d;

  always_comb begin
    step_rd = step_q[s1_ch_q];
    case (s1_d_q[3:1])
      3'd4:    mult = 8'd77;
      3'd5:    mult = 8'd102;
      3'd6:    mult = 8'd128;
      3'd7:    mult = 8'd153;
      default: mult = 8'd57;
    endcase
    delta_d = 16'((19'(s1_d_q) * 19'(step_rd)) >> 3);
    nstep_d = 17'((23'(mult) * 23'(step_rd)) >> 6);
  end

  // stage III: sign application
  logic [16:0] sdelta_d;
  always_comb begin
    sdelta_d = {1'b0, s2_delta_q};
    if (s2_sign_q) sdelta_d = -sdelta_d;
  end

  // stage IV: accumulate with saturation, clamp step
  logic signed [16:0] sum_d, xnew_d;
  logic [14:0]        stepnew_d;

  always_comb begin
    sum_d  = x_q[s3_ch_q] + $signed(s3_delta_q);
    xnew_d = sum_d;
    // Magnitude overflow past 16 bits shows up as bit16 != bit15; the nibble sign tells the direction.
    if (sum_d[16] != sum_d[15]) xnew_d = s3_sign_q ? -17'sd32768 : 17'sd32767;
    if (s3_nstep_q < 17'(STEPMIN))      stepnew_d = 15'(STEPMIN);
    else if (s3_nstep_q > 17'(STEPMAX)) stepnew_d = 15'(STEPMAX);
    else                                stepnew_d = s3_nstep_q[14:0];
  end

  logic wb;
  assign wb = s4_vld_q & ~kill[s4_ch_q];

  // pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0; s1_sign_q <= 1'b0; s1_d_q <= '0; s1_ch_q <= '0;
      s2_vld_q <= 1'b0; s2_sign_q <= 1'b0; s2_delta_q <= '0; s2_nstep_q <= '0; s2_ch_q <= '0;
      s3_vld_q <= 1'b0; s3_sign_q <= 1'b0; s3_delta_q <= '0; s3_nstep_q <= '0; s3_ch_q <= '0;
      s4_vld_q <= 1'b0; s4_x_q <= '0; s4_step_q <= '0; s4_ch_q <= '0;
      clr_pend_q <= '0;
    end else if (cen) begin
      clr_pend_q <= '0;
      s1_vld_q   <= accept;
      if (accept) begin
        s1_d_q    <= {data[2:0], 1'b1};
        s1_sign_q <= data[3];
        s1_ch_q   <= adv_ch;
      end
      s2_vld_q   <= s1_vld_q & ~kill[s1_ch_q];
      s2_delta_q <= delta_d;
      s2_nstep_q <= nstep_d;
      s2_sign_q  <= s1_sign_q;
      s2_ch_q    <= s1_ch_q;
      s3_vld_q   <= s2_vld_q & ~kill[s2_ch_q];
      s3_delta_q <= sdelta_d;
      s3_nstep_q <= s2_nstep_q;
      s3_sign_q  <= s2_sign_q;
      s3_ch_q    <= s2_ch_q;
      s4_vld_q   <= s3_vld_q & ~kill[s3_ch_q];
      s4_x_q     <= xnew_d;
      s4_step_q  <= stepnew_d;
      s4_ch_q    <= s3_ch_q;
    end else begin
      clr_pend_q <= clr_pend_q | clr;
    end
  end

  // channel state: a kill overrides a same-edge write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CH; n++) begin
        x_q[n]    <= '0;
        step_q[n] <= 15'(STEPMIN);
      end
    end else if (cen) begin
      for (int n = 0; n < CH; n++) begin
        if (kill[n]) begin
          x_q[n]    <= '0;
          step_q[n] <= 15'(STEPMIN);
        end else if (wb && s4_ch_q == CW'(n)) begin
          x_q[n]    <= s4_x_q;
          step_q[n] <= s4_step_q;
        end
      end
    end
  end

  // result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm       <= '0;
      pcm_ch    <= '0;
      pcm_valid <= 1'b0;
    end else if (cen) begin
      pcm_valid <= wb;
      if (wb) begin
        pcm    <= s4_x_q[15:0];
        pcm_ch <= s4_ch_q;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_all
    assign pcm_all[g*16 +: 16] = x_q[g][15:0];
  end

endmodule

// File: tb/tb_jt10_adpcmb_mch.sv
module tb_jt10_adpcmb_mch;
  localparam int CH = 6;
  localparam int CW = 3;
  localparam bit [CH-1:0] ALL = '1;

  logic               rst_n, clk, cen, adv, rdy, pcm_valid;
  logic [3:0]         data;
  logic [CW-1:0]      adv_ch, pcm_ch;
  logic [CH-1:0]      chon, clr;
  logic signed [15:0] pcm;
  logic [CH*16-1:0]   pcm_all;

  jt10_adpcmb_mch #(.CH(CH), .CW(CW), .STEPMIN(127), .STEPMAX(24576)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .data(data), .adv(adv), .adv_ch(adv_ch),
    .rdy(rdy), .chon(chon), .clr(clr), .pcm(pcm), .pcm_ch(pcm_ch),
    .pcm_valid(pcm_valid), .pcm_all(pcm_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: decoded sample and step per channel, list of requests in flight
  typedef struct { int ch; int nib; int acc; } req_t;
  int         x_m [CH];
  int         st_m[CH];
  bit [CH-1:0] pend_m;
  req_t       fl[$];
  int         cyc;
  int         exp_vld, exp_pcm, exp_pch;

  function automatic void model_reset();
    for (int n = 0; n < CH; n++) begin
      x_m[n] = 0; st_m[n] = 127;
    end
    pend_m = '0; fl.delete(); exp_vld = 0; exp_pcm = 0; exp_pch = 0;
  endfunction

  // ADPCM-B step: plain integer arithmetic with clamping
  function automatic void apply(int ch, int nib);
    int mag, d, dl, m;
    mag = nib % 8;
    d   = 2 * mag + 1;
    dl  = (d * st_m[ch]) / 8;
    if (nib >= 8) dl = -dl;
    x_m[ch] = x_m[ch] + dl;
    if (x_m[ch] > 32767)  x_m[ch] = 32767;
    if (x_m[ch] < -32768) x_m[ch] = -32768;
    case (mag)
      4: m = 77; 5: m = 102; 6: m = 128; 7: m = 153;
      default: m = 57;
    endcase
    st_m[ch] = (m * st_m[ch]) / 64;
    if (st_m[ch] < 127)   st_m[ch] = 127;
    if (st_m[ch] > 24576) st_m[ch] = 24576;
  endfunction

  // a channel stays busy for the three cen cycles after its acceptance
  function automatic bit model_rdy(int ch);
    if (ch >= CH) return 1'b0;
    foreach (fl[i]) if (fl[i].ch == ch && fl[i].acc >= cyc - 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outs();
    chk("pcm_valid", pcm_valid, exp_vld);
    chk("pcm", pcm, exp_pcm);
    chk("pcm_ch", pcm_ch, exp_pch);
    for (int n = 0; n < CH; n++) chk("pcm_all", pcm_all[n*16 +: 16], x_m[n] & 'hFFFF);
  endtask

  task automatic cycle(input bit c_en, input bit a, input int ch, input bit [3:0] nib,
                       input bit [CH-1:0] on, input bit [CH-1:0] cl, output bit got_rdy);
    bit er;
    bit [CH-1:0] kl;
    req_t keep[$];
    @(negedge clk);
    cen = c_en; adv = a; adv_ch = ch[CW-1:0]; data = nib; chon = on; clr = cl;
    #1;
    er = model_rdy(ch);
    got_rdy = rdy;
    chk("rdy", rdy, er);
    @(posedge clk);
    if (c_en) begin
      kl = ~on | cl | pend_m;
      exp_vld = 0;
      foreach (fl[i]) begin
        if (fl[i].acc + 4 == cyc) begin
          if (!kl[fl[i].ch]) begin
            apply(fl[i].ch, fl[i].nib);
            exp_vld = 1; exp_pcm = x_m[fl[i].ch]; exp_pch = fl[i].ch;
          end
        end else if (!kl[fl[i].ch]) begin
          keep.push_back(fl[i]);
        end
      end
      fl = keep;
      for (int n = 0; n < CH; n++) if (kl[n]) begin x_m[n] = 0; st_m[n] = 127; end
      if (a && er && !kl[ch]) fl.push_back('{ch: ch, nib: int'(nib), acc: cyc});
      pend_m = '0;
      cyc++;
    end else begin
      pend_m |= cl;
    end
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    bit r;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 4'h0, ALL, '0, r);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pcm", pcm, 0);
    chk("rst_pcm_valid", pcm_valid, 0);
    chk("rst_pcm_ch", pcm_ch, 0);
    for (int n = 0; n < CH; n++) chk("rst_pcm_all", pcm_all[n*16 +: 16], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit r;
    int acc_n;
    rst_n = 1'b0; cen = 1'b0; adv = 1'b0; adv_ch = '0; data = '0; chon = ALL; clr = '0;
    cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pcm", pcm, 0);
    chk("reset_valid", pcm_valid, 0);
    chk("reset_all", pcm_all[15:0], 0);
    rst_n = 1'b1;

    // first nibble from power-up
    cycle(1, 1, 0, 4'h7, ALL, '0, r);
    idle(4);
    chk("first_valid", pcm_valid, 1);
    chk("first_pcm", pcm, 238);
    // step 303 shows through a zero nibble: 303/8 = 37
    cycle(1, 1, 0, 4'h0, ALL, '0, r);
    idle(4);
    chk("step303_pcm", pcm, 275);

    // negative nibble on ch1 from reset, step clamps back to 127
    reset_pulse();
    cycle(1, 1, 1, 4'h8, ALL, '0, r);
    idle(4);
    chk("neg_pcm", pcm, -15);
    chk("neg_ch", pcm_ch, 1);
    chk("neg_ch0_field", pcm_all[15:0], 0);
    cycle(1, 1, 1, 4'h0, ALL, '0, r);
    idle(4);
    chk("clamp_step_pcm", pcm, 0);

    // saturation both ways
    for (int i = 0; i < 480; i++) cycle(1, 1, 0, 4'h7, ALL, '0, r);
    idle(4);
    chk("sat_hi", pcm, 32767);
    for (int i = 0; i < 200; i++) cycle(1, 1, 0, 4'hF, ALL, '0, r);
    idle(4);
    chk("sat_lo", pcm, -32768);

    // back-to-back same channel then rotating channels
    reset_pulse();
    cycle(1, 1, 0, 4'h3, ALL, '0, r);
    chk("b2b_first_rdy", r, 1);
    cycle(1, 1, 0, 4'h3, ALL, '0, r);
    chk("b2b_second_rdy", r, 0);
    idle(5);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        cycle(1, 1, c, 4'(c + 4 * k), ALL, '0, r);
        chk("rot_rdy", r, 1);
      end
    idle(5);

    // clear two cen after acceptance kills the request
    cycle(1, 1, 0, 4'h7, ALL, '0, r);
    idle(1);
    cycle(1, 0, 0, 4'h0, ALL, 6'b000001, r);
    idle(4);
    chk("clr_x0", pcm_all[15:0], 0);
    cycle(1, 1, 0, 4'h0, ALL, '0, r);
    idle(4);
    chk("clr_step_pcm", pcm, 15);
    // clear while cen low, applied on the next cen
    cycle(1, 1, 0, 4'h7, ALL, '0, r);
    cycle(0, 0, 0, 4'h0, ALL, 6'b000001, r);
    idle(5);
    chk("clr_latched_x0", pcm_all[15:0], 0);

    // disable ch1 while its nibble is in flight
    cycle(1, 1, 1, 4'h7, ALL, '0, r);
    idle(4);
    cycle(1, 1, 1, 4'h7, ALL, '0, r);
    cycle(1, 0, 0, 4'h0, ALL & ~6'b000010, '0, r);
    idle(5);
    chk("chon_x1", pcm_all[31:16], 0);

    // randomized traffic with a mid-stream reset
    acc_n = 0;
    for (int i = 0; i < 3000; i++) begin
      bit [CH-1:0] on, cl;
      on = ALL;
      cl = '0;
      if ($urandom_range(0, 29) == 0) on[$urandom_range(0, CH-1)] = 1'b0;
      if ($urandom_range(0, 39) == 0) cl[$urandom_range(0, CH-1)] = 1'b1;
      if (i == 1500) reset_pulse();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 7),
            4'($urandom_range(0, 15)), on, cl, r);
      if (pcm_valid) acc_n++;
    end
    idle(6);
    chk("rand_results_seen", acc_n > 100, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/jt10_adpcmb_mch.md
JT10_ADPCMB_MCH -- requirements
Module: jt10_adpcmb_mch

Interface
REQ-001 SHALL have parameter CH, default 2, meaning number of time-multiplexed ADPCM-B channels (1..8).
REQ-002 SHALL have parameter CW, default $clog2(CH) (minimum 1), meaning channel index width.
REQ-003 SHALL have parameter STEPMIN, default 127, meaning lower step clamp and reset step.
REQ-004 SHALL have parameter STEPMAX, default 24576, meaning upper step clamp.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous active-low reset; clk  in  1  single clock for all logic.
REQ-006 SHALL have ports: cen  in  1  clock enable, all state advances only when high; data  in  4  ADPCM nibble (bit3 sign, bits2:0 magnitude).
REQ-007 SHALL have ports: adv  in  1  nibble request; adv_ch  in  CW  target channel; rdy  out  1  request accepted this cen.
REQ-008 SHALL have ports: chon  in  CH  per-channel enable mask; clr  in  CH  per-channel clear pulse mask.
REQ-009 SHALL have ports: pcm  out  16 signed  last result; pcm_ch  out  CW  channel of pcm; pcm_valid  out  1  one-cen-cycle result strobe; pcm_all  out  CH*16  current sample of every channel, channel 0 in LSBs.

Function
REQ-010 SHALL keep per-channel state x (17-bit signed) and step (15-bit unsigned) in register arrays, one shared 4-stage pipeline.
REQ-011 SHALL accept a request on a cen cycle when adv=1, rdy=1, chon[adv_ch]=1 and clr[adv_ch]=0; otherwise the nibble is dropped.
REQ-012 SHALL drive rdy low combinationally when adv_ch matches any valid in-flight stage channel (read-after-write hazard); else high.
REQ-013 Stage I SHALL register d = {data[2:0],1}, sign = data[3], channel, valid.
REQ-014 Stage II SHALL compute delta = (d*step)>>3 (16 bits), nstep = (mult*step)>>6 (17 bits); mult = 57 for magnitude 0..3, 77/102/128/153 for 4/5/6/7.
REQ-015 Stage III SHALL negate delta when sign=1 (two's complement, 17 bits).
REQ-016 Stage IV SHALL compute x+delta in 17 bits; on overflow (bit16 != bit15) saturate to -32768 if sign=1 else 32767; step = clamp(nstep, STEPMIN, STEPMAX); write both back.
REQ-017 Latency: request accepted at cen edge k SHALL write back, update pcm/pcm_ch/pcm_all and assert pcm_valid after cen edge k+4; pcm_valid SHALL fall after the next cen edge; cen low holds all outputs.
REQ-018 Pipeline SHALL sustain one request per cen for rotating channels (throughput 1 sample/cen when CH>=4).
REQ-019 clr[n]=1 on a cen cycle SHALL set x[n]=0, step[n]=STEPMIN and kill all in-flight stages of channel n (no pcm_valid); clr wins over simultaneous adv and write-back to n.
REQ-020 chon[n]=0 SHALL hold x[n]=0, step[n]=STEPMIN, reject requests to n and kill its in-flight stages.
REQ-021 clr asserted while cen=0 SHALL be latched and applied on the next cen cycle.
REQ-022 adv_ch >= CH SHALL be ignored, rdy low.

Reset
REQ-023 rst_n low SHALL asynchronously set all x=0, step=STEPMIN, pipeline valid bits 0, pending clr 0, pcm=0, pcm_ch=0, pcm_valid=0, pcm_all=0.
REQ-024 Reset mid-operation SHALL discard in-flight requests; first request after release behaves as from power-up.

Verification
REQ-025 Reset, chon=all, adv ch0 data=0x7 -> 4 cen later pcm_valid, pcm=238, pcm_ch=0; step[0]=303.
REQ-026 From reset, ch1 data=0x8 -> pcm=-15; step[1] clamped to 127 (113 < 127); pcm_all ch0 field stays 0.
REQ-027 Stream 0x7 to ch0 repeatedly -> pcm monotonically rises, saturates at 32767, step saturates at 24576, never wraps; then 0xF stream -> saturates at -32768.
REQ-028 adv ch0 two consecutive cen cycles -> rdy=0 on second cycle, nibble dropped; adv ch0, ch1, ch0... with CH>=4 alternated with ch2, ch3 -> rdy always 1, four results in order.
REQ-029 clr[0] pulse two cen after accepting ch0 nibble -> no pcm_valid for that request, x[0]=0, step[0]=127; clr during cen=0 applied next cen.
REQ-030 chon[1] dropped while ch1 in flight -> no result for ch1, pcm_all ch1 field 0; rst_n pulsed mid-stream -> all outputs 0 immediately, no stale pcm_valid after release.
